// File: rtl/reversible_ripple_uncompute.sv
// Bit-serial uncompute of a reversible ripple-carry adder: recovers b, the ancillas and
// a final-carry check from the forward adder's sum/cout/a/garbage lines, one stage per cycle.
module reversible_ripple_uncompute #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] sum,
   input  logic             cout,
   input  logic             cin,
   input  logic [WIDTH-1:0] g_a,
   input  logic [WIDTH-1:0] g_ab,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] b_rec,
   output logic [WIDTH-1:0] anc_rec,
   output logic             carry_ok,
   output logic             anc_clean,
   output logic             busy
);

   localparam int unsigned IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             c_q, c_d;
   logic [WIDTH-1:0] sum_q, sum_d, ga_q, ga_d, gab_q, gab_d;
   logic             cout_q, cout_d;
   logic [WIDTH-1:0] bacc_q, bacc_d, aacc_q, aacc_d;
   logic [WIDTH-1:0] b_rec_q, b_rec_d, anc_rec_q, anc_rec_d;
   logic             carry_ok_q, carry_ok_d, anc_clean_q, anc_clean_d;
   logic             p, b_bit, a_bit;

   assign p     = sum_q[idx_q] ^ c_q;
   assign b_bit = p ^ ga_q[idx_q];
   assign a_bit = gab_q[idx_q] ^ (ga_q[idx_q] & b_bit);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      c_d         = c_q;
      sum_d       = sum_q;
      ga_d        = ga_q;
      gab_d       = gab_q;
      cout_d      = cout_q;
      bacc_d      = bacc_q;
      aacc_d      = aacc_q;
      b_rec_d     = b_rec_q;
      anc_rec_d   = anc_rec_q;
      carry_ok_d  = carry_ok_q;
      anc_clean_d = anc_clean_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sum_d   = sum;
               ga_d    = g_a;
               gab_d   = g_ab;
               cout_d  = cout;
               c_d     = cin;
               idx_d   = '0;
               bacc_d  = '0;
               aacc_d  = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            bacc_d[idx_q] = b_bit;
            aacc_d[idx_q] = a_bit;
            c_d           = (p & c_q) ^ gab_q[idx_q];
            // Result registers take the accumulators including the stage finishing on this edge.
            if (idx_q == LAST) begin
               b_rec_d     = bacc_d;
               anc_rec_d   = aacc_d;
               carry_ok_d  = (c_d == cout_q);
               anc_clean_d = (aacc_d == '0);
               state_d     = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         c_q         <= 1'b0;
         sum_q       <= '0;
         ga_q        <= '0;
         gab_q       <= '0;
         cout_q      <= 1'b0;
         bacc_q      <= '0;
         aacc_q      <= '0;
         b_rec_q     <= '0;
         anc_rec_q   <= '0;
         carry_ok_q  <= 1'b0;
         anc_clean_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         c_q         <= c_d;
         sum_q       <= sum_d;
         ga_q        <= ga_d;
         gab_q       <= gab_d;
         cout_q      <= cout_d;
         bacc_q      <= bacc_d;
         aacc_q      <= aacc_d;
         b_rec_q     <= b_rec_d;
         anc_rec_q   <= anc_rec_d;
         carry_ok_q  <= carry_ok_d;
         anc_clean_q <= anc_clean_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign b_rec     = b_rec_q;
   assign anc_rec   = anc_rec_q;
   assign carry_ok  = carry_ok_q;
   assign anc_clean = anc_clean_q;

endmodule

// File: tb/tb_reversible_ripple_uncompute.sv
// Directed and randomized bench for reversible_ripple_uncompute (WIDTH=8).
module tb_reversible_ripple_uncompute;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] sum = '0;
   logic         cout = 1'b0;
   logic         cin = 1'b0;
   logic [W-1:0] g_a = '0;
   logic [W-1:0] g_ab = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] b_rec;
   logic [W-1:0] anc_rec;
   logic         carry_ok;
   logic         anc_clean;
   logic         busy;

   int total = 0;
   int bad   = 0;

   reversible_ripple_uncompute #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .sum(sum), .cout(cout), .cin(cin), .g_a(g_a), .g_ab(g_ab),
      .out_valid(out_valid), .out_ready(out_ready), .b_rec(b_rec), .anc_rec(anc_rec),
      .carry_ok(carry_ok), .anc_clean(anc_clean), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: walk the stages as plain integers (dirty-ancilla cases).
   task automatic model(input logic [W-1:0] s, input logic co, input logic ci,
                        input logic [W-1:0] a, input logic [W-1:0] gab,
                        output logic [W-1:0] eb, output logic [W-1:0] ea,
                        output logic eok, output logic ecl);
      int c = ci;
      eb = '0;
      ea = '0;
      for (int i = 0; i < W; i++) begin
         int pp, bb;
         pp = s[i] ^ c;
         bb = pp ^ a[i];
         eb[i] = bb[0];
         ea[i] = gab[i] ^ (a[i] & bb[0]);
         c = (pp & c) ^ gab[i];
      end
      eok = (c[0] == co);
      ecl = (ea == '0);
   endtask

   task automatic run_vec(input string tag, input logic [W-1:0] s, input logic co, input logic ci,
                          input logic [W-1:0] a, input logic [W-1:0] gab, input int hold,
                          input logic [W-1:0] eb, input logic [W-1:0] ea,
                          input logic eok, input logic ecl);
      int n = 0;
      @(negedge clk);
      chk({tag, ".in_ready"}, in_ready, 1);
      in_valid  = 1'b1;
      sum       = s;
      cout      = co;
      cin       = ci;
      g_a       = a;
      g_ab      = gab;
      out_ready = (hold == 0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      while (!out_valid && n < 40) begin
         @(posedge clk);
         #1 n++;
      end
      chk({tag, ".latency"}, n, W);
      @(negedge clk);
      chk({tag, ".b_rec"}, b_rec, eb);
      chk({tag, ".anc_rec"}, anc_rec, ea);
      chk({tag, ".carry_ok"}, carry_ok, eok);
      chk({tag, ".anc_clean"}, anc_clean, ecl);
      chk({tag, ".busy"}, busy, 1);
      for (int h = 0; h < hold; h++) begin
         chk({tag, ".hold_valid"}, out_valid, 1);
         chk({tag, ".hold_b"}, b_rec, eb);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, ".ov_drop"}, out_valid, 0);
      chk({tag, ".ready_back"}, in_ready, 1);
   endtask

   initial begin
      logic [W-1:0] ra, rb, ranc, gab, eb, ea;
      logic [W:0]   full;
      logic         rci, rco, eok, ecl;
      int           n;

      // Reset state
      #2;
      chk("rst.out_valid", out_valid, 0);
      chk("rst.busy", busy, 0);
      chk("rst.b_rec", b_rec, 0);
      chk("rst.carry_ok", carry_ok, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk("rst.in_ready", in_ready, 1);

      // Directed vectors
      run_vec("v1", 8'h10, 1'b0, 1'b0, 8'h0F, 8'h01, 0, 8'h01, 8'h00, 1'b1, 1'b1);
      run_vec("v2", 8'h00, 1'b1, 1'b0, 8'hFF, 8'h01, 0, 8'h01, 8'h00, 1'b1, 1'b1);
      run_vec("v3", 8'h08, 1'b0, 1'b0, 8'h00, 8'h04, 0, 8'h00, 8'h04, 1'b1, 1'b0);
      run_vec("v4", 8'h10, 1'b1, 1'b0, 8'h0F, 8'h01, 0, 8'h01, 8'h00, 1'b0, 1'b1);

      // Back-pressure with other data on the inputs
      @(negedge clk);
      in_valid = 1'b1; sum = 8'h10; cout = 1'b0; cin = 1'b0; g_a = 8'h0F; g_ab = 8'h01;
      out_ready = 1'b0;
      @(posedge clk);
      #1 sum = 8'hA5; g_a = 8'h3C; g_ab = 8'hFF; cout = 1'b1; cin = 1'b1;
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk);
         #1 n++;
      end
      chk("bp.latency", n, W);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp.out_valid", out_valid, 1);
         chk("bp.in_ready", in_ready, 0);
         chk("bp.b_rec", b_rec, 8'h01);
         chk("bp.anc_rec", anc_rec, 8'h00);
         chk("bp.carry_ok", carry_ok, 1);
         chk("bp.anc_clean", anc_clean, 1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp.release_ov", out_valid, 0);
      chk("bp.release_ready", in_ready, 1);
      chk("bp.release_busy", busy, 0);
      in_valid = 1'b0;

      // Abort with reset at stage idx=4
      @(negedge clk);
      in_valid = 1'b1; sum = 8'h00; cout = 1'b1; cin = 1'b0; g_a = 8'hFF; g_ab = 8'h01;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 chk("abort.midrun", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("abort.busy", busy, 0);
      chk("abort.ov", out_valid, 0);
      chk("abort.b_rec", b_rec, 0);
      chk("abort.anc_rec", anc_rec, 0);
      chk("abort.carry_ok", carry_ok, 0);
      chk("abort.anc_clean", anc_clean, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk("abort.in_ready", in_ready, 1);
      n = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1 if (out_valid) n++;
      end
      chk("abort.no_ov", n, 0);
      run_vec("post", 8'h08, 1'b0, 1'b0, 8'h00, 8'h04, 0, 8'h00, 8'h04, 1'b1, 1'b0);

      // Random: clean ancillas follow real addition; dirty ones use the stage walk
      for (int t = 0; t < 24; t++) begin
         ra   = W'($urandom);
         rb   = W'($urandom);
         rci  = 1'($urandom);
         full = {1'b0, ra} + {1'b0, rb} + (W+1)'(rci);
         if (t % 2 == 0) begin
            run_vec("rnd_clean", full[W-1:0], full[W], rci, ra, ra & rb,
                    $urandom_range(0, 3), rb, '0, 1'b1, 1'b1);
         end else begin
            ranc = W'($urandom);
            gab  = (ra & rb) ^ ranc;
            rco  = full[W] ^ 1'($urandom);
            model(full[W-1:0], rco, rci, ra, gab, eb, ea, eok, ecl);
            run_vec("rnd_dirty", full[W-1:0], rco, rci, ra, gab,
                    $urandom_range(0, 3), eb, ea, eok, ecl);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reversible_ripple_uncompute.md
REVERSIBLE_RIPPLE_UNCOMPUTE -- requirements
Module: reversible_ripple_uncompute

Interface
REQ-001 Parameter: WIDTH, 8, number of ripple stages processed; the block SHALL operate for any WIDTH from 2 to 32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  input vector present.
REQ-005 in_ready  output  1  block accepts a vector this cycle.
REQ-006 sum  input  WIDTH  forward-adder sum lines.
REQ-007 cout  input  1  forward-adder final carry.
REQ-008 cin  input  1  forward-adder carry-in.
REQ-009 g_a  input  WIDTH  preserved a lines from the forward adder.
REQ-010 g_ab  input  WIDTH  per-stage garbage, (a&b)^anc.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 b_rec  output  WIDTH  recovered b operand.
REQ-014 anc_rec  output  WIDTH  recovered ancilla values; all-zero when the ancillas are clean.
REQ-015 carry_ok  output  1  recomputed final carry equals cout.
REQ-016 anc_clean  output  1  anc_rec is all-zero.
REQ-017 busy  output  1  high while in state RUN or DONE.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-019 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0, and input ports SHALL be ignored.
REQ-020 On a rising edge with state IDLE and in_valid=1, the block SHALL capture sum, cout, cin, g_a and g_ab, set stage index idx=0, load the carry register with cin, and enter RUN.
REQ-021 The block SHALL process exactly one stage per cycle in RUN, from idx=0 upward: p=sum[idx]^c, b_rec_w[idx]=p^g_a[idx], anc_rec_w[idx]=g_ab[idx]^(g_a[idx]&b_rec_w[idx]), c<=(p&c)^g_ab[idx].
REQ-022 When the stage with idx=WIDTH-1 is processed, the block SHALL enter DONE and, on that edge, load b_rec, anc_rec, carry_ok=(final c == captured cout) and anc_clean=(anc_rec_w==0) into the output registers.
REQ-023 Latency SHALL be fixed: out_valid rises exactly WIDTH cycles after the acceptance edge (8 for the default WIDTH), independent of data.
REQ-024 In DONE, out_valid SHALL be 1, and all result outputs SHALL be held stable until the handshake completes.
REQ-025 On a rising edge in DONE with out_ready=1, the block SHALL return to IDLE and deassert out_valid; a new vector is acceptable no earlier than the following edge, so there is no same-cycle re-accept.
REQ-026 When out_ready=0, the block SHALL remain in DONE indefinitely, with no loss of and no change to the result.
REQ-027 Result outputs SHALL keep their last values in IDLE and RUN; they are meaningful only while out_valid=1.
REQ-028 idx SHALL be a ceil(log2(WIDTH))-bit counter that never wraps past WIDTH-1; reaching WIDTH-1 SHALL always terminate RUN.
REQ-029 All arithmetic SHALL be single-bit XOR/AND, with no width extension; only the final c is compared against cout, since the intermediate carries are not available as inputs.

Reset
REQ-030 While rst_n=0, the block SHALL immediately (asynchronously) force state=IDLE, idx=0, c=0, b_rec=0, anc_rec=0, carry_ok=0, anc_clean=0, out_valid=0, busy=0.
REQ-031 in_ready SHALL be 1 on the first cycle after rst_n deasserts.
REQ-032 A reset asserted during RUN or DONE SHALL abort the operation, discard the partial result, and produce no out_valid pulse for the aborted vector.

Verification
REQ-033 The bench SHALL drive sum=0x10, cout=0, cin=0, g_a=0x0F, g_ab=0x01, with out_ready=1 -> out_valid exactly 8 cycles after acceptance, b_rec=0x01, anc_rec=0x00, carry_ok=1, anc_clean=1.
REQ-034 The bench SHALL drive sum=0x00, cout=1, cin=0, g_a=0xFF, g_ab=0x01 -> b_rec=0x01, anc_rec=0x00, carry_ok=1, anc_clean=1 (full carry ripple through all 8 stages).
REQ-035 The bench SHALL drive sum=0x08, cout=0, cin=0, g_a=0x00, g_ab=0x04 (dirty ancilla on bit 2) -> b_rec=0x00, anc_rec=0x04, anc_clean=0, carry_ok=1.
REQ-036 The bench SHALL repeat the REQ-033 vector with cout=1 -> carry_ok=0, and b_rec=0x01 unchanged.
REQ-037 The bench SHALL hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and different input data driven throughout -> out_valid stays 1, outputs stay unchanged, in_ready stays 0; the first out_ready=1 edge returns the block to IDLE.
REQ-038 The bench SHALL assert rst_n=0 at stage idx=4 of RUN, then release it -> all outputs zero, in_ready=1 on the next cycle, no out_valid for the aborted vector, and the next vector completes normally.
